// File: rtl/tt10_lab_2_pkg.sv
// rtl/tt10_lab_2_pkg.sv - shared constants, payload type and decode function for the lab-2 datapath
// Purpose: word width, shift-flag bit position, stage payload layout and the
//          decode function that recovers A from {C, B, shift}.
// Ports:   none (package)
package tt10_lab_2_pkg;

  localparam int DATA_W    = 8;
  localparam int SHIFT_BIT = 7;

  // Stage-1 payload: raw encoded word, key and the transmitted shift flag.
  typedef struct packed {
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] b;
    logic              shift;
  } s1_payload_t;

  localparam int S1_W = $bits(s1_payload_t);
  localparam int S2_W = DATA_W + 1;

  // Returns {err, data}. A shifted word lost A[7] on the way out, but the flag
  // tells us it was 1; its LSB must be the zero shifted in by the encoder.
  function automatic logic [DATA_W:0] decode(input logic [DATA_W-1:0] c,
                                             input logic [DATA_W-1:0] b,
                                             input logic              shift);
    logic [DATA_W-1:0] a;
    logic              err;
    if (shift) begin
      a   = {1'b1, c[DATA_W-1:1] ^ b[DATA_W-2:0]};
      err = c[0];
    end else begin
      a   = c ^ b;
      err = a[SHIFT_BIT];
    end
    return {err, a};
  endfunction

endpackage

// File: rtl/tt10_lab_2_pipe_slice.sv
// rtl/tt10_lab_2_pipe_slice.sv - one valid/ready register slice with parameterised payload
// Purpose: single elastic pipeline stage; accepts when empty or draining.
// Ports:   clk, rst_n          clock, synchronous active-low reset
//          in_valid/in_ready   upstream handshake, in_data payload in
//          out_valid/out_ready downstream handshake, out_data payload out
module tt10_lab_2_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Can take a word when empty, or when the held word leaves this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tt10_lab_2_decoder.sv
// rtl/tt10_lab_2_decoder.sv - two-stage elastic lab-2 decoder with word/error counters
// Purpose: recovers A from encoded word C, key B and shift flag; flags
//          inconsistent words; counts delivered words and delivered errors.
// Ports:   clk, rst_n                      clock, synchronous active-low reset
//          enc_data, key, enc_shift        input word C, key B, shift flag
//          in_valid/in_ready               input handshake
//          dec_data, dec_err               recovered A and consistency error
//          out_valid/out_ready             output handshake
//          clr_cnt                         synchronous counter clear
//          word_count, err_count           delivered words (wraps), errors (saturates)
module tt10_lab_2_decoder
  import tt10_lab_2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] enc_data,
  input  logic [DATA_W-1:0] key,
  input  logic              enc_shift,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] dec_data,
  output logic              dec_err,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  err_count
);

  s1_payload_t       s1_in;
  s1_payload_t       s1_q;
  logic [S1_W-1:0]   s1_data;
  logic              s1_valid;
  logic              s2_ready;
  logic [S2_W-1:0]   s2_in;
  logic [S2_W-1:0]   s2_data;
  logic              xfer;

  assign s1_in = '{c: enc_data, b: key, shift: enc_shift};

  // Stage 1 ready chains through stage 2, giving
  // in_ready = !s1_valid || !s2_valid || out_ready.
  tt10_lab_2_pipe_slice #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign s1_q  = s1_payload_t'(s1_data);
  assign s2_in = decode(s1_q.c, s1_q.b, s1_q.shift);

  tt10_lab_2_pipe_slice #(.W(S2_W)) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign dec_err  = s2_data[S2_W-1];
  assign dec_data = s2_data[DATA_W-1:0];

  assign xfer = out_valid && out_ready;

  // Clear wins over a same-cycle delivery; that delivery goes uncounted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_count <= '0;
      err_count  <= '0;
    end else if (clr_cnt) begin
      word_count <= '0;
      err_count  <= '0;
    end else if (xfer) begin
      word_count <= word_count + CNT_W'(1);
      if (dec_err && (err_count != {CNT_W{1'b1}})) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tt10_lab_2_decoder.sv
// tb/tb_tt10_lab_2_decoder.sv - scoreboard bench for the lab-2 decoder
module tb_tt10_lab_2_decoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] enc_data;
  logic [7:0] key;
  logic       enc_shift;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dec_data;
  logic       dec_err;
  logic       out_valid;
  logic       out_ready;
  logic       clr_cnt;
  logic [7:0] word_count;
  logic [7:0] err_count;

  tt10_lab_2_decoder #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enc_data   (enc_data),
    .key        (key),
    .enc_shift  (enc_shift),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dec_data   (dec_data),
    .dec_err    (dec_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clr_cnt    (clr_cnt),
    .word_count (word_count),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         acc_n      = 0;
  logic [7:0] mdl_wc     = 8'd0;
  logic [7:0] mdl_ec     = 8'd0;

  // Independent reference: {err, A} from (C, B, flag).
  function automatic logic [8:0] ref_decode(input logic [7:0] c, input logic [7:0] b, input logic s);
    logic [7:0] t;
    if (s) begin
      t = ((c >> 1) ^ (b & 8'h7F)) | 8'h80;
      return {c[0], t};
    end
    t = c ^ b;
    return {t[7], t};
  endfunction

  // One clock: drive, settle, record handshakes against the scoreboard, then
  // advance to 1 ns after the next rising edge.
  task automatic step(input logic v, input logic [7:0] c, input logic [7:0] b,
                      input logic s, input logic ordy, input logic clr);
    logic [8:0] e;
    in_valid = v; enc_data = c; key = b; enc_shift = s; out_ready = ordy; clr_cnt = clr;
    #1;
    if (!rst_n) begin
      exp_q.delete();
      mdl_wc = 8'd0;
      mdl_ec = 8'd0;
    end else begin
      if (v && in_ready) begin
        exp_q.push_back(ref_decode(c, b, s));
        acc_n++;
      end
      if (out_valid && ordy) begin
        got_q.push_back({dec_err, dec_data});
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL scoreboard_extra: got %h, required no output", {dec_err, dec_data});
        end else begin
          e = exp_q.pop_front();
          if ({dec_err, dec_data} !== e) begin
            mismatched++;
            $display("FAIL scoreboard_word: got %h, required %h", {dec_err, dec_data}, e);
          end
        end
        if (!clr) begin
          mdl_wc++;
          if (dec_err && mdl_ec != 8'hFF) mdl_ec++;
        end
      end
      if (clr) begin
        mdl_wc = 8'd0;
        mdl_ec = 8'd0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_timeout: %0d words pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 8'hAA, 8'h55, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hAA, 8'h55, 1'b0, 1'b1, 1'b0);
    compared++;
    if ({out_valid, word_count, err_count, dec_data, dec_err} !== 26'd0) begin
      mismatched++;
      $display("FAIL reset_state: ov=%b wc=%h ec=%h dd=%h de=%b, required all 0",
               out_valid, word_count, err_count, dec_data, dec_err);
    end
    rst_n = 1'b1;
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_no_accept: out_valid=%b, required 0", out_valid);
    end
    got_q.delete();
    step(1'b1, 8'h66, 8'h33, 1'b0, 1'b1, 1'b0);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL latency_early: out_valid=%b after 1 edge, required 0", out_valid);
    end
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    compared++;
    if ({out_valid, dec_err, dec_data} !== {1'b1, 1'b0, 8'h55}) begin
      mismatched++;
      $display("FAIL latency_2: ov=%b de=%b dd=%h, required ov=1 de=0 dd=55", out_valid, dec_err, dec_data);
    end
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    compared++;
    if (word_count !== 8'd1) begin
      mismatched++;
      $display("FAIL first_count: word_count=%0d, required 1", word_count);
    end
  endtask

  task automatic test_shift_decode();
    got_q.delete();
    step(1'b1, 8'hCC, 8'h33, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    drain();
    compared++;
    if (got_q.size() != 2 || got_q[0] !== 9'h0D5 || got_q[1] !== 9'h1FF) begin
      mismatched++;
      $display("FAIL shift_decode: got %0d words %h %h, required 0d5 1ff",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 9'h0, got_q.size() > 1 ? got_q[1] : 9'h0);
    end
  endtask

  task automatic test_error_check();
    logic [7:0] ec0;
    ec0 = err_count;
    got_q.delete();
    step(1'b1, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'h02, 8'h00, 1'b1, 1'b1, 1'b0);
    drain();
    compared++;
    if (got_q.size() != 2 || got_q[0] !== 9'h180 || got_q[1] !== 9'h081) begin
      mismatched++;
      $display("FAIL error_words: got %0d words %h %h, required 180 081",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 9'h0, got_q.size() > 1 ? got_q[1] : 9'h0);
    end
    compared++;
    if (err_count !== ec0 + 8'd1 || err_count !== mdl_ec) begin
      mismatched++;
      $display("FAIL err_count_inc: err_count=%h, required %h", err_count, ec0 + 8'd1);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] cs[5];
    logic [7:0] bs[5];
    int k;
    int cyc;
    cs = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00};
    bs = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    got_q.delete();
    acc_n = 0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, cs[k], bs[k], 1'b0, 1'b0, 1'b0);
      k = acc_n;
    end
    compared++;
    if (acc_n != 2 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_accept: accepted=%0d in_ready=%b, required 2 and 0", acc_n, in_ready);
    end
    step(1'b1, cs[k], bs[k], 1'b0, 1'b0, 1'b0);
    compared++;
    if ({out_valid, dec_err, dec_data} !== {1'b1, 1'b0, 8'h11} || acc_n != 2) begin
      mismatched++;
      $display("FAIL bp_hold: ov=%b de=%b dd=%h acc=%0d, required 1 0 11 2", out_valid, dec_err, dec_data, acc_n);
    end
    cyc = 0;
    while (got_q.size() < 4 && cyc < 10) begin
      step(k < 4, cs[k], bs[k], 1'b0, 1'b1, 1'b0);
      k = (acc_n < 4) ? acc_n : 4;
      cyc++;
    end
    compared++;
    if (cyc != 4 || got_q.size() != 4) begin
      mismatched++;
      $display("FAIL bp_rate: %0d words in %0d cycles, required 4 in 4", got_q.size(), cyc);
    end
    compared++;
    if (got_q.size() != 4 || got_q[0] !== 9'h011 || got_q[1] !== 9'h022 ||
        got_q[2] !== 9'h033 || got_q[3] !== 9'h044) begin
      mismatched++;
      $display("FAIL bp_order: got %0d words, required 011 022 033 044 in order", got_q.size());
    end
    drain();
  endtask

  task automatic test_counters();
    int guard;
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    compared++;
    if (word_count !== 8'd0 || err_count !== 8'd0) begin
      mismatched++;
      $display("FAIL clr_idle: wc=%h ec=%h, required 00 00", word_count, err_count);
    end
    acc_n = 0;
    guard = 0;
    while (acc_n < 260 && guard < 400) begin
      step(1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    drain();
    compared++;
    if (word_count !== 8'd4 || word_count !== mdl_wc) begin
      mismatched++;
      $display("FAIL word_wrap: word_count=%0d, required 4", word_count);
    end
    compared++;
    if (err_count !== 8'hFF || err_count !== mdl_ec) begin
      mismatched++;
      $display("FAIL err_saturate: err_count=%h, required ff", err_count);
    end
    step(1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL clr_setup: out_valid=%b, required 1", out_valid);
    end
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    compared++;
    if (word_count !== 8'd0 || err_count !== 8'd0) begin
      mismatched++;
      $display("FAIL clr_on_xfer: wc=%h ec=%h, required 00 00", word_count, err_count);
    end
  endtask

  task automatic test_reset_mid_stream();
    step(1'b1, 8'h10, 8'h01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h20, 8'h02, 1'b0, 1'b0, 1'b0);
    compared++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_fill: ov=%b in_ready=%b, required 1 0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    compared++;
    if (out_valid !== 1'b0 || dec_data !== 8'h00) begin
      mismatched++;
      $display("FAIL mid_reset: ov=%b dd=%h, required 0 00", out_valid, dec_data);
    end
    rst_n = 1'b1;
    got_q.delete();
    step(1'b1, 8'h5A, 8'h0F, 1'b0, 1'b1, 1'b0);
    drain();
    compared++;
    if (got_q.size() != 1 || got_q[0] !== 9'h055) begin
      mismatched++;
      $display("FAIL mid_first_out: got %0d words first %h, required 1 word 055",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 9'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; enc_data = 8'h00; key = 8'h00;
    enc_shift = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_shift_decode();
    test_error_check();
    test_backpressure();
    test_counters();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
